iir_sos_cascade: RTL

IIR_SOS_CASCADE -- requirements
Module: iir_sos_cascade

---
 rtl/iir_pkg.sv | 27 ++
 rtl/iir_mult_accum.sv | 67 ++++++
 rtl/round_n_sat.sv | 34 +++
 rtl/iir_sos_cascade.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared types and constants for the biquad cascade.
// Also carries a real-to-fixed helper for coefficient tables.
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WB
  } state_t;

  localparam int B0   = 0;
  localparam int B1   = 1;
  localparam int B2   = 2;
  localparam int NA1  = 3;
  localparam int NA2  = 4;
  localparam int NK   = 5;
  localparam int ACCW = 48;

  function automatic longint to_fixed(real r, int frac);
    real s;
    s = r * (2.0 ** frac);
    if (s >= 0.0) return longint'($rtoi(s + 0.5));
    return longint'($rtoi(s - 0.5));
  endfunction

endpackage

// File: rtl/iir_mult_accum.sv
// Pipelined signed multiply-accumulate, LAT cycles issue to acc.
// load replaces the accumulator, otherwise the product is added.
module iir_mult_accum #(
  parameter int AW   = 25,
  parameter int BW   = 18,
  parameter int ACCW = 48,
  parameter int LAT  = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   load,
  input  logic signed [AW-1:0]   a,
  input  logic signed [BW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);

  localparam int PW = AW + BW;

  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] pext;
  logic                   v_l;
  logic                   ld_l;
  logic signed [ACCW-1:0] p_l;

  assign prod = a * b;
  assign pext = {{(ACCW-PW){prod[PW-1]}}, prod};

  generate
    if (LAT == 1) begin : g_direct
      assign v_l  = en;
      assign ld_l = load;
      assign p_l  = pext;
    end else begin : g_pipe
      logic [LAT-2:0]         v_q;
      logic [LAT-2:0]         ld_q;
      logic signed [ACCW-1:0] p_q [LAT-1];

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          v_q  <= '0;
          ld_q <= '0;
          for (int i = 0; i < LAT-1; i++) p_q[i] <= '0;
        end else begin
          v_q[0]  <= en;
          ld_q[0] <= load;
          p_q[0]  <= pext;
          for (int i = 1; i < LAT-1; i++) begin
            v_q[i]  <= v_q[i-1];
            ld_q[i] <= ld_q[i-1];
            p_q[i]  <= p_q[i-1];
          end
        end
      end

      assign v_l  = v_q[LAT-2];
      assign ld_l = ld_q[LAT-2];
      assign p_l  = p_q[LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  acc <= '0;
    else if (v_l) acc <= ld_l ? p_l : acc + p_l;
  end

endmodule

// File: rtl/round_n_sat.sv
// Round half-up by dropping SHIFT LSBs, then clamp to OW bits.
// sat flags any clamp.
module round_n_sat #(
  parameter int IW    = 48,
  parameter int OW    = 25,
  parameter int SHIFT = 14
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 sat
);

  localparam logic signed [IW:0] HALF = (IW+1)'(1) << (SHIFT-1);

  logic signed [IW:0] sum;
  logic signed [IW:0] shr;
  logic               hi_ones;
  logic               hi_zero;

  assign sum     = {din[IW-1], din} + HALF;
  assign shr     = sum >>> SHIFT;
  assign hi_ones = &shr[IW:OW-1];
  assign hi_zero = ~|shr[IW:OW-1];
  assign sat     = !(hi_ones || hi_zero);

  always_comb begin
    dout = shr[OW-1:0];
    if (sat) begin
      if (shr[IW]) dout = {1'b1, {(OW-1){1'b0}}};
      else         dout = {1'b0, {(OW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/iir_sos_cascade.sv
// Cascade of Direct Form I biquads time-shared over one MAC.
// Each section: 5 issues, MAC drain, one write-back cycle.
module iir_sos_cascade
  import iir_pkg::*;
#(
  parameter int NSEC    = 4,
  parameter int NDINT   = 3,
  parameter int NDFRAC  = 22,
  parameter int NCINT   = 4,
  parameter int NCFRAC  = 14,
  parameter int MAC_LAT = 3,
  localparam int DW     = NDINT + NDFRAC,
  localparam int CW     = NCINT + NCFRAC,
  localparam int NCOEF  = NK * NSEC,
  localparam int AW     = $clog2(NCOEF)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          bypass,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          sat_flag,
  input  logic          sat_clr
);

  localparam int SW  = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int NS2 = 1 << SW;
  localparam int NCA = 1 << AW;
  localparam int LW  = $clog2(MAC_LAT + 1);
  localparam logic signed [CW-1:0] ONE = CW'(1) << NCFRAC;

  state_t state_q, state_d;

  logic [2:0]    k_q;
  logic [LW-1:0] d_q;
  logic [SW-1:0] s_q;
  logic          accept;
  logic          last_k;
  logic          last_d;
  logic          last_s;
  logic          byp_q;

  logic signed [DW-1:0] cur_x;
  logic signed [DW-1:0] byp_data;
  logic signed [CW-1:0] coef [NCA];
  logic signed [DW-1:0] x1 [NS2];
  logic signed [DW-1:0] x2 [NS2];
  logic signed [DW-1:0] y1 [NS2];
  logic signed [DW-1:0] y2 [NS2];

  logic [AW-1:0]          cidx;
  logic                   mac_en;
  logic                   mac_ld;
  logic signed [DW-1:0]   mac_a;
  logic signed [CW-1:0]   mac_b;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   y;
  logic                   sat;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign last_k   = (k_q == 3'd4);
  assign last_d   = (d_q == LW'(MAC_LAT - 1));
  assign last_s   = (s_q == SW'(NSEC - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !bypass) state_d = ISSUE;
      ISSUE:   if (last_k) state_d = DRAIN;
      DRAIN:   if (last_d) state_d = WB;
      WB:      state_d = last_s ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      k_q <= '0;
      d_q <= '0;
      s_q <= '0;
    end else begin
      if (state_q == ISSUE) k_q <= last_k ? 3'd0 : k_q + 3'd1;
      if (state_q == DRAIN) d_q <= last_d ? '0 : d_q + 1'b1;
      if (accept)               s_q <= '0;
      else if (state_q == WB)   s_q <= s_q + 1'b1;
    end
  end

  // b0,b1,b2 pair with x,x1,x2; -a1,-a2 with y1,y2
  assign cidx   = AW'(NK * int'(s_q) + int'(k_q));
  assign mac_en = (state_q == ISSUE);
  assign mac_ld = (k_q == 3'd0);
  assign mac_b  = coef[cidx];

  always_comb begin
    mac_a = cur_x;
    unique case (k_q)
      3'd1:    mac_a = x1[s_q];
      3'd2:    mac_a = x2[s_q];
      3'd3:    mac_a = y1[s_q];
      3'd4:    mac_a = y2[s_q];
      default: mac_a = cur_x;
    endcase
  end

  iir_mult_accum #(
    .AW   (DW),
    .BW   (CW),
    .ACCW (ACCW),
    .LAT  (MAC_LAT)
  ) u_mac (
    .clk    (clk),
    .resetn (resetn),
    .en     (mac_en),
    .load   (mac_ld),
    .a      (mac_a),
    .b      (mac_b),
    .acc    (acc)
  );

  round_n_sat #(
    .IW    (ACCW),
    .OW    (DW),
    .SHIFT (NCFRAC)
  ) u_rns (
    .din  (acc),
    .dout (y),
    .sat  (sat)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCA; i++)
        coef[i] <= ((i % NK) == B0) ? ONE : '0;
    end else if (coef_we && int'(coef_addr) < NCOEF) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_x     <= '0;
      byp_q     <= 1'b0;
      byp_data  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
      for (int i = 0; i < NS2; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      out_valid <= byp_q;
      byp_q     <= accept && bypass;
      if (byp_q) out_data <= byp_data;
      if (accept) begin
        cur_x    <= in_data;
        byp_data <= in_data;
      end
      if (state_q == WB) begin
        x1[s_q] <= cur_x;
        x2[s_q] <= x1[s_q];
        y1[s_q] <= y;
        y2[s_q] <= y1[s_q];
        cur_x   <= y;
        if (last_s) begin
          out_valid <= 1'b1;
          out_data  <= y;
        end
      end
      if (state_q == WB && sat) sat_flag <= 1'b1;
      else if (sat_clr)         sat_flag <= 1'b0;
    end
  end

endmodule
